// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : FIFO-buffered UART transmitter; 8N1 frames, LSB first, sent
//            back-to-back. Define UART_TX_PARITY_EN to add an even parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 10_000_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  data_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic                        serial_out,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);
    localparam int AW               = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_bit_end;
    logic             w_line;
    logic [7:0]       w_head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_head        = r_mem[r_rd_ptr[AW-1:0]];
    assign w_bit_end     = (r_cnt == CNT_LAST);
    assign data_in_ready = !w_full;
    assign w_push        = data_in_valid && !w_full;
    assign w_pop         = !w_empty &&
                           ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    assign fifo_count    = r_wr_ptr - r_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_START:  w_line = 1'b0;
            S_DATA:   w_line = r_shift[r_idx];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_line = ^r_shift;
`endif
            default:  w_line = 1'b1;
        endcase
    end

    // Line and busy flag are registered from the current state, so the line
    // lags the state by one cycle and each symbol spans the full bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            serial_out <= w_line;
            tx_busy    <= (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_cnt   <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (!w_empty) begin
                            r_shift <= w_head;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
